// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, BCD digit width and counter width helper.
package hex_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Counter must hold the value BIN_W itself.
    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// Ports: i_digit (4-bit BCD digit), o_digit (adjusted 4-bit digit).
module bcd_dabble_digit
    import hex_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Input is at most 9, so the sum stays within 4 bits (max 12).
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5)
            o_digit = i_digit + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock.
// Ports: clk, rst, start, bin_in -> busy, valid, bcd_out, blank, overflow.
module bin_to_bcd_seq
    import hex_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]             blank,
    output logic                          overflow
);

    localparam int CW = cnt_w(BIN_W);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [BIN_W-1:0] r_bin;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    logic            r_valid;
    logic [BW-1:0]   r_bcd_out;
    logic [DIGITS-1:0] r_blank;
    logic            r_overflow;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_bcd_nxt;
    logic            w_ovf_nxt;
    logic [DIGITS-1:0] w_blank;
    logic            w_last;
    logic            w_busy;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_dabble_digit u_dig (
            .i_digit (r_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_digit (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // Adjusted digits shift left, pulling in the next binary MSB.
    assign w_bcd_nxt = {w_adj[BW-2:0], r_bin[BIN_W-1]};
    assign w_ovf_nxt = r_ovf | w_adj[BW-1];
    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(1));

    // Leading-zero mask, scanned from the top digit downwards.
    always_comb begin
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (w_bcd_nxt[BCD_DIGIT_W*i +: BCD_DIGIT_W] != '0)
                v_zero = 1'b0;
            w_blank[i] = v_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start)  w_next = SHIFT;
            SHIFT: if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_bin <= '0;
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_cnt <= CW'(BIN_W);
                r_bin <= bin_in;
                r_bcd <= '0;
                r_ovf <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
            r_bin <= r_bin << 1;
            r_bcd <= w_bcd_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_bcd_out  <= '0;
            r_blank    <= BLANK_RST;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_last) begin
                r_bcd_out  <= w_bcd_nxt;
                r_blank    <= w_blank;
                r_overflow <= w_ovf_nxt;
            end
        end
    end

    assign busy     = w_busy;
    assign valid    = r_valid;
    assign bcd_out  = r_bcd_out;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (5-digit and 4-digit instances).
// Table vectors, random values against a decimal model, corner sequences.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;

    logic        busy5, valid5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  blank5;
    logic        busy4, valid4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u5 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy5), .valid(valid5), .bcd_out(bcd5),
        .blank(blank5), .overflow(ovf5)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy4), .valid(valid4), .bcd_out(bcd4),
        .blank(blank4), .overflow(ovf4)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] b5;
        logic [4:0]  k5;
        logic        o5;
        logic [15:0] b4;
        logic [3:0]  k4;
        logic        o4;
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int unsigned dig(input int unsigned v, input int i);
        return int'((longint'(v) / pow10(i)) % 10);
    endfunction

    function automatic logic [63:0] m_bcd(input int unsigned v, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'(dig(v, i));
        return r;
    endfunction

    function automatic logic [63:0] m_blank(input int unsigned v, input int d);
        logic [63:0] r = '0;
        bit z = 1'b1;
        for (int i = d - 1; i > 0; i--) begin
            if (dig(v, i) != 0) z = 1'b0;
            r[i] = z;
        end
        return r;
    endfunction

    function automatic logic [63:0] m_ovf(input int unsigned v, input int d);
        return {63'd0, (longint'(v) >= pow10(d))};
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (valid5) break;
        end
    endtask

    // Starts a conversion; returns edges from accept to valid and busy errors.
    task automatic do_conv(input logic [15:0] v, output int n, output int bad);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        bad = 0;
        while (n < 40) begin
            if (!busy5 || !busy4) bad++;
            @(posedge clk); #1;
            n++;
            if (valid5) break;
        end
    endtask

    task automatic check_model(input string nm, input int unsigned v);
        chk({nm, "_bcd5"},   64'(bcd5),   m_bcd(v, 5));
        chk({nm, "_blank5"}, 64'(blank5), m_blank(v, 5));
        chk({nm, "_ovf5"},   64'(ovf5),   m_ovf(v, 5));
        chk({nm, "_bcd4"},   64'(bcd4),   m_bcd(v, 4));
        chk({nm, "_blank4"}, 64'(blank4), m_blank(v, 4));
        chk({nm, "_ovf4"},   64'(ovf4),   m_ovf(v, 4));
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"},   64'(busy5),  64'd0);
        chk({nm, "_valid"},  64'(valid5), 64'd0);
        chk({nm, "_bcd5"},   64'(bcd5),   64'd0);
        chk({nm, "_blank5"}, 64'(blank5), 64'h1e);
        chk({nm, "_ovf5"},   64'(ovf5),   64'd0);
        chk({nm, "_blank4"}, 64'(blank4), 64'he);
    endtask

    initial begin
        int n;
        int bad;
        int vcnt;
        int unsigned v;

        tab[0] = '{16'd42,    20'h00042, 5'b11100, 1'b0, 16'h0042, 4'b1100, 1'b0};
        tab[1] = '{16'd65535, 20'h65535, 5'b00000, 1'b0, 16'h5535, 4'b0000, 1'b1};
        tab[2] = '{16'd0,     20'h00000, 5'b11110, 1'b0, 16'h0000, 4'b1110, 1'b0};
        tab[3] = '{16'd7,     20'h00007, 5'b11110, 1'b0, 16'h0007, 4'b1110, 1'b0};
        tab[4] = '{16'd1234,  20'h01234, 5'b10000, 1'b0, 16'h1234, 4'b0000, 1'b0};
        tab[5] = '{16'd500,   20'h00500, 5'b11000, 1'b0, 16'h0500, 4'b1000, 1'b0};
        tab[6] = '{16'd12345, 20'h12345, 5'b00000, 1'b0, 16'h2345, 4'b0000, 1'b1};
        tab[7] = '{16'd9999,  20'h09999, 5'b10000, 1'b0, 16'h9999, 4'b0000, 1'b0};
        tab[8] = '{16'd10000, 20'h10000, 5'b00000, 1'b0, 16'h0000, 4'b1110, 1'b1};
        tab[9] = '{16'd100,   20'h00100, 5'b11000, 1'b0, 16'h0100, 4'b1000, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        #12;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Latency and one-cycle valid pulse for 42.
        do_conv(16'd42, n, bad);
        chk("lat42", 64'(n), 64'd16);
        chk("busy42", 64'(bad), 64'd0);
        chk("busy_fall42", 64'(busy5), 64'd0);
        chk("valid4_42", 64'(valid4), 64'd1);
        @(posedge clk); #1;
        chk("pulse42", 64'(valid5), 64'd0);
        chk("hold42", 64'(bcd5), 64'h42);

        for (int i = 0; i < 10; i++) begin
            do_conv(tab[i].bin, n, bad);
            chk($sformatf("lat_t%0d", i), 64'(n), 64'd16);
            chk($sformatf("busy_t%0d", i), 64'(bad), 64'd0);
            chk($sformatf("bcd5_t%0d", i), 64'(bcd5), 64'(tab[i].b5));
            chk($sformatf("blank5_t%0d", i), 64'(blank5), 64'(tab[i].k5));
            chk($sformatf("ovf5_t%0d", i), 64'(ovf5), 64'(tab[i].o5));
            chk($sformatf("bcd4_t%0d", i), 64'(bcd4), 64'(tab[i].b4));
            chk($sformatf("blank4_t%0d", i), 64'(blank4), 64'(tab[i].k4));
            chk($sformatf("ovf4_t%0d", i), 64'(ovf4), 64'(tab[i].o4));
        end

        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(0, 65535);
            do_conv(16'(v), n, bad);
            chk($sformatf("lat_r%0d", i), 64'(n), 64'd16);
            check_model($sformatf("rnd%0d", i), v);
        end

        // start during busy is ignored.
        @(negedge clk);
        bin_in = 16'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bin_in = 16'd999;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 16'd0;
        wait_valid(n);
        chk("lat_ign", 64'(n), 64'd12);
        chk("bcd_ign", 64'(bcd5), 64'h7);

        // start in the valid cycle is accepted.
        bin_in = 16'd1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy5), 64'd1);
        wait_valid(n);
        chk("b2b_lat", 64'(n), 64'd16);
        check_model("b2b", 1234);
        @(posedge clk); #1;
        chk("b2b_noretrig", 64'(busy5), 64'd0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bin_in = 16'd500;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (valid5 || busy5) vcnt++;
        end
        chk("midrst_quiet", 64'(vcnt), 64'd0);
        chk("midrst_bcd", 64'(bcd5), 64'd0);
        do_conv(16'd500, n, bad);
        chk("after_rst_lat", 64'(n), 64'd16);
        chk("after_rst_bcd", 64'(bcd5), 64'h00500);
        check_model("after_rst", 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative (shift-add-3 / double-dabble) binary-to-BCD converter, one bit per clock. It sits directly upstream of the 7-segment hex decoders. Each 4-bit slice of bcd_out drives one decoder's nibble input, so a binary value shows in decimal across the digit row. It also produces a leading-zero blank mask so the display stage can suppress unused high digits.

Parameters:
BIN_W, 16, width of the binary input (>=1).
DIGITS, 5, number of BCD digits produced (>=1); slice i = bcd_out[4*i+3:4*i], digit 0 = least significant.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a conversion of bin_in; sampled only in IDLE.
bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge only.
busy  output  1  high while a conversion is in progress (SHIFT state).
valid  output  1  one-cycle pulse: bcd_out/blank/overflow just updated.
bcd_out  output  4*DIGITS  packed BCD result, held until the next completion.
blank  output  DIGITS  bit i = 1 when digit i is a leading zero (bit 0 always 0).
overflow  output  1  last result did not fit in DIGITS digits; held with bcd_out.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - busy=0, valid=0, overflow=0, bcd_out=0.
  - blank = all ones except bit 0.
  - FSM=IDLE; internal shift register and counter = 0.
- States: IDLE, SHIFT.
- IDLE: on an edge with start=1:
  - load bin_in into the binary shift register;
  - clear the BCD working register and overflow accumulator;
  - counter=BIN_W; go to SHIFT.
- SHIFT, each edge:
  - every working digit >=5 gets +3 (4-bit result);
  - then the concatenation {bcd_work, bin_shift} shifts left by 1;
  - if the bit leaving the top digit is 1, set the overflow accumulator;
  - counter decrements.
- SHIFT, edge with counter==1:
  - the final shift result is registered directly into bcd_out, overflow, blank;
  - valid=1 for exactly the next cycle; FSM -> IDLE.
- Latency: start sampled at edge k -> valid high in the cycle following edge k+BIN_W. Outputs change on that same edge.
- Busy: high from edge k through edge k+BIN_W, and falls in the same cycle valid rises.
- Throughput: start may be high during the valid cycle (FSM is IDLE). It is accepted, giving back-to-back conversions every BIN_W+1 cycles.
- start while busy: ignored; bin_in is not re-sampled. No queueing.
- bcd_out, blank and overflow are never updated mid-conversion. The display stage sees only complete results.
- Blank rule: blank[i]=1 iff i>0 and digits i..DIGITS-1 are all zero. Computed from the final result and registered with bcd_out.
- Overflow: the sticky OR of all bits shifted out of the top digit. Overflow never occurs if DIGITS >= ceil(BIN_W*log10(2)).
- Reset mid-conversion: abort immediately; outputs return to reset values; no valid is produced.
- No arithmetic wider than 4 bits per digit; the add-3 never exceeds 4'd12 because the input digit is <=9.

Decomposition:
- Shared package hex_pkg holds:
  - state enum (IDLE, SHIFT);
  - localparam BCD_DIGIT_W=4;
  - the counter width function $clog2(BIN_W+1).
- One sub-module, bcd_dabble_digit, combinational:
  - function: 4-bit in -> add-3 adjusted 4-bit out;
  - instantiation: generate-instantiated DIGITS times.
- The top module holds the FSM, counter, shift registers and output registers.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> immediately busy=0, valid=0, bcd_out=20'h00000, blank=5'b11110, overflow=0.
2. start with bin_in=16'd42 at edge k:
   - busy=1 for edges k..k+16;
   - valid pulse after edge k+16;
   - bcd_out=20'h00042, blank=5'b11100, overflow=0.
3. bin_in=16'd65535 -> bcd_out=20'h65535, blank=5'b00000, overflow=0. Then bin_in=0 -> bcd_out=20'h00000, blank=5'b11110.
4. Busy/back-to-back:
   - start=1 with bin_in=16'd999 during busy of a 16'd7 conversion is ignored, result 20'h00007;
   - start asserted in the valid cycle with 16'd1234 is accepted, next valid exactly 17 cycles later, bcd_out=20'h01234.
5. Reset mid-conversion: start 16'd500, assert rst after 8 shift edges -> no valid pulse, outputs at reset values. The next start with 16'd500 gives 20'h00500.
6. DIGITS=4, BIN_W=16, bin_in=16'd12345 -> bcd_out=16'h2345, overflow=1, blank=4'b0000. Then 16'd9999 -> 16'h9999, overflow=0.
